// File: rtl/mips_pkg.sv
// mips_pkg: shared register-file constants and word/index types.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;
  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_RA = 5'd31;
endpackage

// File: rtl/wb_register_file_read_port.sv
// regfile_read_port: index-to-data mux with $0 forcing; write-first bypass when REGFILE_BYPASS_EN is defined.
module regfile_read_port #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic [DATA_W-1:0] regs [NUM_REGS],
  input  logic [ADDR_W-1:0] rd_idx,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);
`ifdef REGFILE_BYPASS_EN
  always_comb rd_data = (rd_idx == ADDR_W'(mips_pkg::REG_ZERO)) ? '0 :
                        (wr_en && wr_idx == rd_idx) ? wr_data : regs[rd_idx];
`else
  logic unused_byp;
  assign unused_byp = ^{wr_en, wr_idx, wr_data};
  always_comb rd_data = (rd_idx == ADDR_W'(mips_pkg::REG_ZERO)) ? '0 : regs[rd_idx];
`endif
endmodule

// File: rtl/wb_register_file.sv
// wb_register_file: 32x32 MIPS GPR file with jal-to-$31, hardwired $0 and commit counter; REGFILE_BYPASS_EN enables write-first reads.
module wb_register_file #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int NUM_REGS = 2 ** ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  input  logic              RegWrite_jal,
  output logic [15:0]       WriteCount
);
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [15:0] count_q, count_d;
  logic [ADDR_W-1:0] dest;
  logic commit;
  always_comb begin
    dest = RegWrite_jal ? ADDR_W'(mips_pkg::REG_RA) : WriteReg;
    commit = (RegWrite | RegWrite_jal) && dest != ADDR_W'(mips_pkg::REG_ZERO);
    regs_d = regs_q;
    if (commit) regs_d[dest] = WriteData;
    regs_d[0] = '0;
    count_d = count_q + 16'(commit);
  end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      regs_q <= '{default: '0};
      count_q <= '0;
    end else begin
      regs_q <= regs_d;
      count_q <= count_d;
    end
  assign WriteCount = count_q;
  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rp1 (
    .regs(regs_q), .rd_idx(ReadReg1), .wr_en(commit), .wr_idx(dest), .wr_data(WriteData), .rd_data(ReadData1)
  );
  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rp2 (
    .regs(regs_q), .rd_idx(ReadReg2), .wr_en(commit), .wr_idx(dest), .wr_data(WriteData), .rd_data(ReadData2)
  );
endmodule

// File: doc/wb_register_file.md
Name: wb_register_file

Overview:
- Receiving end of the write-back stage: 32 x 32-bit MIPS general-purpose register file.
- Consumes the write-back result, the destination register number, and the RegWrite/jal controls.
- Serves two combinational read ports to the decode stage.
- Handles jal's implicit destination ($31) and the hardwired-zero $0.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width.
- NUM_REGS, 32, number of architectural registers (2**ADDR_W).

Ports:
- Clk  input  1  system clock; all writes on rising edge.
- Rst  input  1  asynchronous, active-low reset.
- ReadReg1  input  ADDR_W  read port 1 index (rs).
- ReadReg2  input  ADDR_W  read port 2 index (rt).
- ReadData1  output  DATA_W  read port 1 data.
- ReadData2  output  DATA_W  read port 2 data.
- WriteReg  input  ADDR_W  destination index from write-back (rd/rt).
- WriteData  input  DATA_W  write-back result (already muxed with PC+4 for jal).
- RegWrite  input  1  write enable.
- RegWrite_jal  input  1  jal write; forces destination to 31 regardless of WriteReg.
- WriteCount  output  16  number of committed architectural writes since reset.

Behaviour:
- Reset (Rst low, asynchronous):
  - All registers clear to 0.
  - WriteCount clears to 0.
  - Read outputs reflect the cleared registers immediately.
- Effective write:
  - we_eff = RegWrite | RegWrite_jal.
  - dest = RegWrite_jal ? 31 : WriteReg.
- Commit: on rising Clk with Rst high and we_eff=1 and dest!=0, reg[dest] <= WriteData.
- Writes to $0 are discarded; reg[0] reads 0 always.
- WriteCount:
  - Increments by 1 on each commit.
  - Writes to $0 do not count.
  - Wraps 0xFFFF -> 0x0000.
- Reads are combinational with zero latency:
  - ReadDataN = (ReadRegN==0) ? 0 : reg[ReadRegN], subject to bypass below.
  - ReadReg1 == ReadReg2 is legal; both ports return identical data.
- Both RegWrite and RegWrite_jal high: jal wins, dest=31.
- Reset asserted mid-cycle: registers clear asynchronously. A commit on the same edge with Rst low is lost.
- Rst release is synchronised externally; first write honoured on the first rising edge with Rst high.
- X on WriteReg while we_eff=0 has no effect.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-first bypass.
  - If we_eff=1 and dest!=0 and ReadRegN==dest in the same cycle, ReadDataN = WriteData (combinational).
  - This lets write-back and decode share a cycle without a hazard stall.
- Undefined: read-old.
  - ReadDataN returns the pre-edge register contents.
  - The hazard unit must stall one extra cycle for WB->ID dependencies.
- $0 is never bypassed in either mode.

Decomposition:
- Shared package (mips_pkg), constants:
  - REG_ZERO=0
  - REG_RA=31
  - DATA_W=32
  - ADDR_W=5
- Shared package, typedefs:
  - reg_idx_t (5-bit)
  - word_t (32-bit)
- One natural sub-module: regfile_read_port, instantiated twice.
  - Index-to-data mux with zero-register forcing and the optional bypass compare.

Test Plan:
- Reset then read all 32 indices on both ports -> every ReadData = 0x00000000, WriteCount = 0.
- RegWrite=1, WriteReg=8, WriteData=0xDEADBEEF, one edge; ReadReg1=8 -> ReadData1 = 0xDEADBEEF, WriteCount = 1.
- RegWrite=1, WriteReg=0, WriteData=0x12345678 -> ReadData of $0 stays 0, WriteCount unchanged.
- RegWrite_jal=1, WriteReg=5, WriteData=0x00400010 -> reg[31] = 0x00400010, reg[5] unchanged. Repeat with RegWrite=1 also high -> same result.
- Bypass: reg[9]=0x1 pre-loaded. Same cycle: WriteReg=9, WriteData=0x2, ReadReg2=9, sampled before the edge.
  - With REGFILE_BYPASS_EN -> ReadData2 = 0x2.
  - Without -> 0x1.
  - After the edge, both modes -> 0x2.
- Perform 65536 writes to $1 -> WriteCount wraps to 0. Then assert Rst mid-cycle with reg[1] nonzero -> reg[1] = 0 and WriteCount = 0 before the next edge.
